// File: rtl/wb_burst_memtest.sv
// Wishbone B3 burst memory tester: writes an address^seed pattern over a window
// using incrementing bursts, reads it back, and counts mismatching words.
module wb_burst_memtest #(
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter int          BURST_LEN  = 8,
  parameter int          NUM_BURSTS = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        bus_err_o,
  output logic [15:0] err_cnt_o,
  output logic [31:0] first_err_adr_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic [2:0]  dbg_state
);

  localparam int N  = BURST_LEN * NUM_BURSTS;
  localparam int KW = $clog2(N + 1);
  localparam int LB = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WGAP = 3'd2,
    S_RD   = 3'd3,
    S_RGAP = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] k;
  logic [31:0]   seed;
  logic [31:0]   cur_adr;
  logic [31:0]   cur_pat;
  logic          on_bus;
  logic          last_beat;
  logic          last_word;
  logic          all_written;
  logic          start_ok;
  logic          beat_ack;
  logic          beat_err;
  logic          beat_rty;
  logic          rd_mismatch;

  assign cur_adr     = BASE_ADR + (32'(k) << 2);
  assign cur_pat     = cur_adr ^ seed;
  assign on_bus      = (state == S_WR) || (state == S_RD);
  // Burst boundaries are fixed by word index, so a retried burst ends where the original would have.
  assign last_beat   = &k[LB-1:0];
  assign last_word   = (k == KW'(N - 1));
  assign all_written = (k == KW'(N));
  assign start_ok    = (state == S_IDLE) && start_i;

  // Handshake: a beat terminates when cyc&stb are high and the slave answers with
  // ack, err or rty; err outranks rty, which outranks ack.
  assign beat_err    = on_bus && wb_err_i;
  assign beat_rty    = on_bus && !wb_err_i && wb_rty_i;
  assign beat_ack    = on_bus && !wb_err_i && !wb_rty_i && wb_ack_i;
  assign rd_mismatch = beat_ack && (state == S_RD) && (wb_dat_i != cur_pat);

  assign dbg_state   = state;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_i) state_nxt = S_WR;
      S_WR: begin
        if (wb_err_i)                   state_nxt = S_IDLE;
        else if (wb_rty_i)              state_nxt = S_WGAP;
        else if (wb_ack_i && last_beat) state_nxt = S_WGAP;
      end
      S_WGAP: state_nxt = all_written ? S_RD : S_WR;
      S_RD: begin
        if (wb_err_i)                   state_nxt = S_IDLE;
        else if (wb_rty_i)              state_nxt = S_RGAP;
        else if (wb_ack_i && last_word) state_nxt = S_FIN;
        else if (wb_ack_i && last_beat) state_nxt = S_RGAP;
      end
      S_RGAP: state_nxt = S_RD;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state != S_IDLE);
    wb_cyc_o = on_bus;
    wb_stb_o = on_bus;
    wb_we_o  = (state == S_WR);
    wb_adr_o = 32'h0;
    wb_dat_o = 32'h0;
    wb_sel_o = 4'h0;
    wb_cti_o = 3'b000;
    wb_bte_o = 2'b00;
    if (on_bus) begin
      wb_adr_o = cur_adr;
      wb_sel_o = 4'hF;
      wb_cti_o = last_beat ? 3'b111 : 3'b010;
    end
    if (state == S_WR) wb_dat_o = cur_pat;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      k               <= '0;
      seed            <= 32'h0;
      done_o          <= 1'b0;
      bus_err_o       <= 1'b0;
      err_cnt_o       <= 16'h0;
      first_err_adr_o <= 32'h0;
    end else if (start_ok) begin
      k               <= '0;
      seed            <= seed_i;
      done_o          <= 1'b0;
      bus_err_o       <= 1'b0;
      err_cnt_o       <= 16'h0;
      first_err_adr_o <= 32'h0;
    end else begin
      if (beat_err) begin
        bus_err_o <= 1'b1;
        done_o    <= 1'b1;
      end
      if (state == S_FIN) done_o <= 1'b1;
      if (beat_ack) k <= k + 1'b1;
      if ((state == S_WGAP) && all_written) k <= '0;
      if (rd_mismatch) begin
        if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
        // A zero count means no earlier mismatch, because the count never wraps back.
        if (err_cnt_o == 16'h0) first_err_adr_o <= cur_adr;
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_memtest.sv
// Bench for wb_burst_memtest: RAM slave model with waits/err/rty/corruption,
// a table of clean/corrupt passes, hand sequences for err, rty and reset, random passes.
module tb_wb_burst_memtest;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          BL   = 8;
  localparam int          NB   = 4;
  localparam int          N    = BL * NB;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] seed;
    int          max_wait;
    bit          rand_wait;
    logic [31:0] c0;
    logic [31:0] c1;
    bit          midstart;
    logic [15:0] exp_cnt;
    logic [31:0] exp_first;
    int          exp_cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed_in = 32'h0;
  logic        busy, done, bus_err;
  logic [15:0] err_cnt;
  logic [31:0] first_err;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic [2:0]  dbg_state;
  logic [31:0] s_dat;
  logic        ack, err, rty;

  wb_burst_memtest #(.BASE_ADR(BASE), .BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start), .seed_i(seed_in),
    .busy_o(busy), .done_o(done), .bus_err_o(bus_err), .err_cnt_o(err_cnt),
    .first_err_adr_o(first_err), .wb_adr_o(m_adr), .wb_dat_o(m_dat), .wb_sel_o(m_sel),
    .wb_we_o(m_we), .wb_cyc_o(m_cyc), .wb_stb_o(m_stb), .wb_cti_o(m_cti), .wb_bte_o(m_bte),
    .wb_dat_i(s_dat), .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- slave model ----------------
  logic [31:0] mem [0:63];
  int          wait_cnt = 0;
  int          wait_tgt = 0;
  int          wr_acks = 0;
  int          rd_acks = 0;
  bit          rty_used = 1'b0;
  int          max_wait = 0;
  bit          rand_wait = 1'b0;
  int          err_beat = -1;
  int          rty_beat = -1;
  logic [31:0] c0 = NONE;
  logic [31:0] c1 = NONE;
  logic        resp, err_now, rty_now;

  assign resp    = m_cyc && m_stb && (wait_cnt == wait_tgt);
  assign err_now = m_we && (err_beat >= 0) && (wr_acks == err_beat);
  assign rty_now = !m_we && (rty_beat >= 0) && !rty_used && (rd_acks == rty_beat);
  assign err     = resp && err_now;
  assign rty     = resp && !err_now && rty_now;
  assign ack     = resp && !err_now && !rty_now;
  assign s_dat   = mem[m_adr[7:2]] ^ (((m_adr == c0) || (m_adr == c1)) ? 32'h0000_0100 : 32'h0);

  always @(posedge clk) begin
    if (start && !busy) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hDEAD_BEEF ^ 32'(i);
      wait_cnt <= 0;
      wait_tgt <= max_wait;
      wr_acks  <= 0;
      rd_acks  <= 0;
      rty_used <= 1'b0;
    end else if (m_cyc && m_stb) begin
      if (resp) begin
        wait_cnt <= 0;
        wait_tgt <= rand_wait ? int'($urandom_range(32'(max_wait), 32'd0)) : max_wait;
        if (ack && m_we) begin
          mem[m_adr[7:2]] <= m_dat;
          wr_acks <= wr_acks + 1;
        end
        if (ack && !m_we) rd_acks <= rd_acks + 1;
        if (rty) rty_used <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [67:0] exp_q[$];
  int          compares = 0;
  int          fails = 0;
  bit          sb_on = 1'b0;
  bit          prev_hold = 1'b0;
  bit          prev_done = 1'b0;
  int          done_rises = 0;
  logic [75:0] snap_prev = '0;
  vec_t        tbl [5];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return 160'({busy, done, bus_err, err_cnt, first_err, m_adr, m_dat, m_sel,
                 m_we, m_cyc, m_stb, m_cti, m_bte, dbg_state});
  endfunction

  // Reference trace of acknowledged beats for one clean pass: writes then reads.
  function automatic void build_expected(input logic [31:0] s);
    exp_q.delete();
    for (int ph = 0; ph < 2; ph++) begin
      for (int kk = 0; kk < N; kk++) begin
        logic [31:0] a;
        a = BASE + 32'(4 * kk);
        exp_q.push_back({ph == 0, ((kk % BL) == BL - 1) ? 3'b111 : 3'b010, a,
                         (ph == 0) ? (a ^ s) : 32'h0});
      end
    end
  endfunction

  function automatic void model_errors(input logic [31:0] a0, input logic [31:0] a1,
                                       output logic [15:0] cnt, output logic [31:0] first);
    cnt = 16'h0;
    first = 32'h0;
    for (int kk = 0; kk < N; kk++) begin
      logic [31:0] a;
      a = BASE + 32'(4 * kk);
      if ((a == a0) || (a == a1)) begin
        if (cnt == 16'h0) first = a;
        cnt++;
      end
    end
  endfunction

  // One cycle, sampled at the falling edge: beat scoreboard, wait stability, done edges.
  task automatic tick();
    logic [75:0] snap;
    logic [67:0] e;
    @(negedge clk);
    snap = {m_cyc, m_stb, m_we, m_sel, m_cti, m_bte, m_adr, m_dat};
    if (prev_hold && rst_n) check("wait_stable", 160'(snap), 160'(snap_prev));
    if (sb_on && m_cyc && m_stb && ack) begin
      check("beat_expected", 160'(exp_q.size() != 0), 160'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 160'({m_we, m_cti, m_adr, m_we ? m_dat : 32'h0}), 160'(e));
      end
    end
    if (done && !prev_done) done_rises++;
    prev_done = done;
    prev_hold = m_cyc && m_stb && !ack && !err && !rty;
    snap_prev = snap;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_vector(input vec_t v, input string tag);
    int n;
    int bad;
    c0 = v.c0; c1 = v.c1; max_wait = v.max_wait; rand_wait = v.rand_wait;
    err_beat = -1; rty_beat = -1;
    build_expected(v.seed);
    sb_on = 1'b1;
    done_rises = 0;
    seed_in = v.seed;
    start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("%s_start_busy", tag), 160'({busy, m_cyc, m_stb}), 160'(3'b111));
    n = 1;
    while (!done && n < 4000) begin
      if (v.midstart && n == 40) begin
        start = 1'b1;
        seed_in = ~v.seed;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check($sformatf("%s_done", tag), 160'(done), 160'(1));
    if (v.exp_cycles != 0) check($sformatf("%s_done_cycle", tag), 160'(n), 160'(v.exp_cycles));
    check($sformatf("%s_err_cnt", tag), 160'(err_cnt), 160'(v.exp_cnt));
    check($sformatf("%s_first_err", tag), 160'(first_err), 160'(v.exp_first));
    check($sformatf("%s_bus_err_busy", tag), 160'({bus_err, busy}), 160'(2'b00));
    check($sformatf("%s_beats_left", tag), 160'(exp_q.size()), 160'(0));
    bad = 0;
    for (int kk = 0; kk < N; kk++)
      if (mem[kk] !== ((BASE + 32'(4 * kk)) ^ v.seed)) bad++;
    check($sformatf("%s_ram_bad_words", tag), 160'(bad), 160'(0));
    check($sformatf("%s_ram_word_1c", tag), 160'(mem[7]), 160'(32'h0000_001C ^ v.seed));
    sb_on = 1'b0;
    repeat (3) tick();
    check($sformatf("%s_done_once_held", tag), 160'({done_rises, done}), 160'({32'd1, 1'b1}));
  endtask

  task automatic bus_err_test();
    int n;
    int cyc_seen;
    c0 = NONE; c1 = NONE; max_wait = 0; rand_wait = 1'b0; rty_beat = -1; err_beat = 11;
    sb_on = 1'b0;
    seed_in = 32'h0BAD_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(m_cyc && err) && n < 300) begin
      tick();
      n++;
    end
    check("err_seen", 160'(err), 160'(1));
    check("err_beat_adr", 160'({m_we, m_adr}), 160'({1'b1, 32'h0000_002C}));
    tick();
    check("err_cyc_drop", 160'({m_cyc, m_stb}), 160'(2'b00));
    check("err_flags", 160'({bus_err, done, busy}), 160'(3'b110));
    cyc_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_cyc) cyc_seen++;
    end
    check("err_no_read", 160'({cyc_seen, rd_acks}), 160'(0));
    check("err_wr_acks", 160'(wr_acks), 160'(11));
    err_beat = -1;
  endtask

  task automatic retry_test();
    int n;
    c0 = NONE; c1 = NONE; max_wait = 0; rand_wait = 1'b0; err_beat = -1; rty_beat = 3;
    build_expected(32'h5EED_1234);
    sb_on = 1'b1;
    done_rises = 0;
    seed_in = 32'h5EED_1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(m_cyc && rty) && n < 300) begin
      tick();
      n++;
    end
    check("rty_seen", 160'(rty), 160'(1));
    check("rty_beat", 160'({m_we, m_adr}), 160'({1'b0, 32'h0000_000C}));
    tick();
    check("rty_gap", 160'({m_cyc, m_stb}), 160'(2'b00));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rty_reissue", 160'({m_cyc, m_we, m_adr, m_cti}),
            160'({1'b1, 1'b0, 32'(12 + 4 * i), (i == 4) ? 3'b111 : 3'b010}));
    end
    n = 0;
    while (!done && n < 4000) begin
      tick();
      n++;
    end
    check("rty_done", 160'(done), 160'(1));
    check("rty_result", 160'({err_cnt, bus_err}), 160'(0));
    check("rty_beats_left", 160'(exp_q.size()), 160'(0));
    check("rty_done_once", 160'(done_rises), 160'(1));
    sb_on = 1'b0;
    rty_beat = -1;
    repeat (3) tick();
  endtask

  task automatic reset_test();
    c0 = NONE; c1 = NONE; max_wait = 0; rand_wait = 1'b0; err_beat = -1; rty_beat = -1;
    sb_on = 1'b0;
    seed_in = 32'h1357_9BDF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("rst_pre_cyc", 160'({m_cyc, m_stb}), 160'(2'b11));
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_cyc", 160'({m_cyc, m_stb}), 160'(2'b00));
    check("rst_async_outputs", all_outs(), 160'(0));
    prev_hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_idle_after_release", all_outs(), 160'(0));
    run_vector(tbl[0], "post_rst");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{32'hA5A5_0000, 0, 1'b0, NONE,         NONE,         1'b0, 16'd0, 32'h0,          73};
    tbl[1] = '{32'hA5A5_0000, 0, 1'b0, 32'h0000_0014, 32'h0000_0040, 1'b0, 16'd2, 32'h0000_0014, 73};
    tbl[2] = '{32'h1234_5678, 2, 1'b0, 32'h0000_007C, NONE,         1'b1, 16'd1, 32'h0000_007C, 201};
    tbl[3] = '{32'hFFFF_FFFF, 0, 1'b0, 32'h0000_001C, 32'h0000_0020, 1'b0, 16'd2, 32'h0000_001C, 73};
    tbl[4] = '{32'h0000_0000, 1, 1'b0, 32'h0000_0080, NONE,         1'b0, 16'd0, 32'h0,          137};

    #1 rst_n = 1'b0;
    tick();
    check("reset_outputs", all_outs(), 160'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", all_outs(), 160'(0));

    for (int i = 0; i < 5; i++) run_vector(tbl[i], $sformatf("vec%0d", i));

    bus_err_test();
    retry_test();
    reset_test();

    for (int r = 0; r < 4; r++) begin
      vec_t v;
      v.seed       = $urandom();
      v.max_wait   = 3;
      v.rand_wait  = 1'b1;
      v.c0         = 32'(4 * $urandom_range(40, 0));
      v.c1         = 32'(4 * $urandom_range(40, 0));
      v.midstart   = 1'b0;
      v.exp_cycles = 0;
      model_errors(v.c0, v.c1, v.exp_cnt, v.exp_first);
      run_vector(v, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
